register_file: RTL and testbench

- 16-entry × 32-bit general-purpose register file for the MIPS datapath.
- One synchronous write port and two independent combinational read ports (A and B).
- Feeds ALU operands.
- Written back from the writeback stage.

---
 rtl/register_file.sv | 44 ++++
 tb/tb_register_file.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// rtl/register_file.sv - 16 x 32 register file, one synchronous write port, two combinational read ports
// Asynchronous active-low reset clears every entry; register 0 is an ordinary writable register.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic [ADDR_WIDTH-1:0] dataInRegister,
  input  logic                  enableSavingDataIn,
  input  logic [ADDR_WIDTH-1:0] dataOutRegisterA,
  input  logic [ADDR_WIDTH-1:0] dataOutRegisterB,
  output logic [DATA_WIDTH-1:0] registerA,
  output logic [DATA_WIDTH-1:0] registerB
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (enableSavingDataIn) begin
      regs_d[dataInRegister] = dataIn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Reads come straight from storage: a same-cycle write shows up only after the edge.
  assign registerA = regs_q[dataOutRegisterA];
  assign registerB = regs_q[dataOutRegisterB];

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard testbench for register_file
// Expected read values are pushed from a bench-side model and popped when the outputs are sampled.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dataIn;
  logic [3:0]  dataInRegister;
  logic        enableSavingDataIn;
  logic [3:0]  dataOutRegisterA;
  logic [3:0]  dataOutRegisterB;
  logic [31:0] registerA;
  logic [31:0] registerB;

  logic [31:0] model [16];
  logic [31:0] exp_a_q [$];
  logic [31:0] exp_b_q [$];
  int errors = 0;
  int checks = 0;

  register_file dut (
    .clk                (clk),
    .rst                (rst),
    .dataIn             (dataIn),
    .dataInRegister     (dataInRegister),
    .enableSavingDataIn (enableSavingDataIn),
    .dataOutRegisterA   (dataOutRegisterA),
    .dataOutRegisterB   (dataOutRegisterB),
    .registerA          (registerA),
    .registerB          (registerB)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    logic [31:0] ea, eb;
    rst = 1'b0;
    enableSavingDataIn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      dataIn = $urandom;
      dataInRegister = 4'(c);
    end
    @(negedge clk);
    enableSavingDataIn = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    for (int i = 0; i < 16; i++) begin
      exp_a_q.push_back(model[i]);
      exp_b_q.push_back(model[15 - i]);
      dataOutRegisterA = 4'(i);
      dataOutRegisterB = 4'(15 - i);
      #1;
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      checks += 2;
      if (registerA !== ea) begin errors++; $display("FAIL reset_a[%0d]: got %h expected %h", i, registerA, ea); end
      if (registerB !== eb) begin errors++; $display("FAIL reset_b[%0d]: got %h expected %h", 15 - i, registerB, eb); end
    end
  endtask

  task automatic test_fill();
    logic [31:0] ea, eb;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      enableSavingDataIn = 1'b1;
      dataInRegister = 4'(i);
      dataIn = 32'(10 * i);
      @(posedge clk);
      #1;
      enableSavingDataIn = 1'b0;
      model[i] = 32'(10 * i);
      exp_a_q.push_back(model[i]);
      exp_b_q.push_back(model[i]);
      dataOutRegisterA = 4'(i);
      dataOutRegisterB = 4'(i);
      #1;
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      checks += 2;
      if (registerA !== ea) begin errors++; $display("FAIL fill_a[%0d]: got %h expected %h", i, registerA, ea); end
      if (registerB !== eb) begin errors++; $display("FAIL fill_b[%0d]: got %h expected %h", i, registerB, eb); end
    end
  endtask

  task automatic test_write_disable();
    logic [31:0] ea, eb;
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      enableSavingDataIn = 1'b0;
      dataIn = 32'd999;
      dataInRegister = 4'(15 - (n % 16));
      dataOutRegisterA = 4'(n / 16);
      dataOutRegisterB = 4'(n % 16);
      exp_a_q.push_back(model[n / 16]);
      exp_b_q.push_back(model[n % 16]);
      #1;
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      checks += 2;
      if (registerA !== ea) begin errors++; $display("FAIL wdis_a[%0d]: got %h expected %h", n / 16, registerA, ea); end
      if (registerB !== eb) begin errors++; $display("FAIL wdis_b[%0d]: got %h expected %h", n % 16, registerB, eb); end
    end
  endtask

  task automatic test_dual_port();
    logic [31:0] ea, eb;
    logic [3:0] pa [3] = '{4'd7, 4'd3, 4'd12};
    logic [3:0] pb [3] = '{4'd7, 4'd12, 4'd3};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      dataOutRegisterA = pa[k];
      dataOutRegisterB = pb[k];
      exp_a_q.push_back(model[pa[k]]);
      exp_b_q.push_back(model[pb[k]]);
      #1;
      ea = exp_a_q.pop_front();
      eb = exp_b_q.pop_front();
      checks += 2;
      if (registerA !== ea) begin errors++; $display("FAIL dual_a[%0d]: got %h expected %h", pa[k], registerA, ea); end
      if (registerB !== eb) begin errors++; $display("FAIL dual_b[%0d]: got %h expected %h", pb[k], registerB, eb); end
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] ea;
    @(negedge clk);
    dataOutRegisterA = 4'd5;
    dataOutRegisterB = 4'd0;
    enableSavingDataIn = 1'b1;
    dataInRegister = 4'd5;
    dataIn = 32'hDEADBEEF;
    exp_a_q.push_back(model[5]);
    #1;
    ea = exp_a_q.pop_front();
    checks++;
    if (registerA !== ea) begin errors++; $display("FAIL rdw_before: got %h expected %h", registerA, ea); end
    @(posedge clk);
    model[5] = 32'hDEADBEEF;
    exp_a_q.push_back(model[5]);
    #1;
    ea = exp_a_q.pop_front();
    checks++;
    if (registerA !== ea) begin errors++; $display("FAIL rdw_after: got %h expected %h", registerA, ea); end
    @(negedge clk);
    dataInRegister = 4'd0;
    dataIn = 32'h1234;
    @(posedge clk);
    #1;
    enableSavingDataIn = 1'b0;
    model[0] = 32'h1234;
    exp_a_q.push_back(model[0]);
    dataOutRegisterA = 4'd0;
    #1;
    ea = exp_a_q.pop_front();
    checks++;
    if (registerA !== ea) begin errors++; $display("FAIL reg0_write: got %h expected %h", registerA, ea); end
  endtask

  task automatic test_async_reset();
    logic [31:0] ea, eb;
    @(negedge clk);
    dataOutRegisterA = 4'd15;
    dataOutRegisterB = 4'd5;
    exp_a_q.push_back(model[15]);
    exp_b_q.push_back(model[5]);
    #1;
    ea = exp_a_q.pop_front();
    eb = exp_b_q.pop_front();
    checks += 2;
    if (registerA !== ea) begin errors++; $display("FAIL pre_rst_a: got %h expected %h", registerA, ea); end
    if (registerB !== eb) begin errors++; $display("FAIL pre_rst_b: got %h expected %h", registerB, eb); end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    exp_a_q.push_back(model[15]);
    exp_b_q.push_back(model[5]);
    #1;
    ea = exp_a_q.pop_front();
    eb = exp_b_q.pop_front();
    checks += 2;
    if (registerA !== ea) begin errors++; $display("FAIL async_rst_a: got %h expected %h", registerA, ea); end
    if (registerB !== eb) begin errors++; $display("FAIL async_rst_b: got %h expected %h", registerB, eb); end
    enableSavingDataIn = 1'b1;
    dataInRegister = 4'd3;
    dataIn = 32'hAAAA5555;
    dataOutRegisterA = 4'd3;
    @(posedge clk);
    exp_a_q.push_back(model[3]);
    #1;
    ea = exp_a_q.pop_front();
    checks++;
    if (registerA !== ea) begin errors++; $display("FAIL write_in_rst: got %h expected %h", registerA, ea); end
    @(negedge clk);
    enableSavingDataIn = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    exp_a_q.push_back(model[3]);
    #1;
    ea = exp_a_q.pop_front();
    checks++;
    if (registerA !== ea) begin errors++; $display("FAIL post_rst_reg3: got %h expected %h", registerA, ea); end
    @(negedge clk);
    enableSavingDataIn = 1'b1;
    dataInRegister = 4'd9;
    dataIn = 32'hCAFE0009;
    @(posedge clk);
    #1;
    enableSavingDataIn = 1'b0;
    model[9] = 32'hCAFE0009;
    dataOutRegisterB = 4'd9;
    exp_b_q.push_back(model[9]);
    #1;
    eb = exp_b_q.pop_front();
    checks++;
    if (registerB !== eb) begin errors++; $display("FAIL post_rst_write: got %h expected %h", registerB, eb); end
  endtask

  initial begin
    rst = 1'b0;
    dataIn = '0;
    dataInRegister = '0;
    enableSavingDataIn = 1'b0;
    dataOutRegisterA = '0;
    dataOutRegisterB = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    test_reset();
    test_fill();
    test_write_disable();
    test_dual_port();
    test_read_during_write();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
